// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl
//   Scans a 5x4 calculator keypad. A one-hot row drive walks the five rows;
//   the active-low column inputs are sampled once per row period. A single
//   clean column starts a debounce. A debounced press gives exactly one
//   o_key_valid strobe with o_key_code = row*4 + col. Release is debounced
//   before scanning resumes on the next row. There is no auto-repeat.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_scan_en    1 = scan, 0 = forced idle (row and code are held)
//   i_col_in     keypad columns, active-low
//   o_row_out    one-hot active-high row drive
//   o_key_valid  single-cycle debounced-press strobe
//   o_key_code   row*4+col of the last press, held until the next strobe
//   o_key_held   high from the strobe until the release is debounced
module keypad_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int DB_CYCLES = 500000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scan_en,
  input  logic [3:0] i_col_in,
  output logic [4:0] o_row_out,
  output logic       o_key_valid,
  output logic [4:0] o_key_code,
  output logic       o_key_held
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  // {valid, column index}; ghost patterns and the idle pattern are not valid
  function automatic logic [2:0] col_decode(input logic [3:0] col);
    logic [2:0] res;
    case (col)
      4'b1110: res = {1'b1, 2'd0};
      4'b1101: res = {1'b1, 2'd1};
      4'b1011: res = {1'b1, 2'd2};
      4'b0111: res = {1'b1, 2'd3};
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  // One-hot row drive to row index 0..4
  function automatic logic [2:0] row_index(input logic [4:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 5; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  state_t           r_state;
  state_t           w_next_state;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [4:0]       r_row, w_row_nxt;
  logic [3:0]       r_pat, w_pat_nxt;
  logic [1:0]       r_col_idx, w_col_idx_nxt;
  logic             r_key_valid, w_valid_nxt;
  logic [4:0]       r_key_code, w_code_nxt;
  logic             r_key_held, w_held_nxt;

  logic [2:0] w_col_dec;
  logic       w_col_ok;
  logic       w_col_idle;
  logic       w_col_match;
  logic       w_div_tc;
  logic       w_cnt_tc;
  logic [4:0] w_row_rot;

  assign w_col_dec   = col_decode(i_col_in);
  assign w_col_ok    = w_col_dec[2];
  assign w_col_idle  = (i_col_in == 4'b1111);
  assign w_col_match = (i_col_in == r_pat);
  assign w_div_tc    = (r_div == DIV_TC);
  assign w_cnt_tc    = (r_cnt == CNT_TC);
  assign w_row_rot   = {r_row[3:0], r_row[4]};

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_SCAN;
      r_div       <= '0;
      r_cnt       <= '0;
      r_row       <= 5'b00001;
      r_pat       <= 4'b1111;
      r_col_idx   <= 2'd0;
      r_key_valid <= 1'b0;
      r_key_code  <= 5'd0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_div       <= w_div_nxt;
      r_cnt       <= w_cnt_nxt;
      r_row       <= w_row_nxt;
      r_pat       <= w_pat_nxt;
      r_col_idx   <= w_col_idx_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_code  <= w_code_nxt;
      r_key_held  <= w_held_nxt;
    end
  end

  // Next-state decode; scan disable overrides every transition
  always_comb begin
    w_next_state = r_state;
    if (!i_scan_en) begin
      w_next_state = ST_SCAN;
    end else begin
      case (r_state)
        ST_SCAN: begin
          if (w_div_tc && w_col_ok) w_next_state = ST_DEBOUNCE;
          else                      w_next_state = ST_SCAN;
        end
        ST_DEBOUNCE: begin
          if (!w_col_match)  w_next_state = ST_SCAN;
          else if (w_cnt_tc) w_next_state = ST_PRESSED;
          else               w_next_state = ST_DEBOUNCE;
        end
        ST_PRESSED: w_next_state = ST_RELEASE;
        ST_RELEASE: begin
          if (w_col_idle && w_cnt_tc) w_next_state = ST_SCAN;
          else                        w_next_state = ST_RELEASE;
        end
        default: w_next_state = ST_SCAN;
      endcase
    end
  end

  // Datapath and registered-output next values
  always_comb begin
    w_div_nxt     = r_div;
    w_cnt_nxt     = r_cnt;
    w_row_nxt     = r_row;
    w_pat_nxt     = r_pat;
    w_col_idx_nxt = r_col_idx;
    w_valid_nxt   = 1'b0;
    w_code_nxt    = r_key_code;
    w_held_nxt    = r_key_held;
    if (!i_scan_en) begin
      // Row and code hold so scanning resumes where it stopped
      w_div_nxt  = '0;
      w_cnt_nxt  = '0;
      w_held_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_SCAN: begin
          if (w_div_tc) begin
            w_div_nxt = '0;
            if (w_col_ok) begin
              // Freeze the row and remember the exact pattern to debounce against
              w_pat_nxt     = i_col_in;
              w_col_idx_nxt = w_col_dec[1:0];
              w_cnt_nxt     = '0;
            end else begin
              w_row_nxt = w_row_rot;
            end
          end else begin
            w_div_nxt = r_div + DIV_W'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (!w_col_match) begin
            w_cnt_nxt = '0;
            w_div_nxt = '0;
          end else if (w_cnt_tc) begin
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_PRESSED: begin
          w_valid_nxt = 1'b1;
          w_code_nxt  = {row_index(r_row), r_col_idx};
          w_held_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
        ST_RELEASE: begin
          if (!w_col_idle) begin
            w_cnt_nxt = '0;
          end else if (w_cnt_tc) begin
            w_cnt_nxt  = '0;
            w_held_nxt = 1'b0;
            w_row_nxt  = w_row_rot;
            w_div_nxt  = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_div_nxt = '0;
          w_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign o_row_out   = r_row;
  assign o_key_valid = r_key_valid;
  assign o_key_code  = r_key_code;
  assign o_key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV  = 4;
  localparam int DB_CYCLES = 8;

  logic       clk;
  logic       rst_n;
  logic       scan_en;
  logic [3:0] col_in;
  logic [4:0] row_out;
  logic       key_valid;
  logic [4:0] key_code;
  logic       key_held;

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DB_CYCLES(DB_CYCLES)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_scan_en  (scan_en),
    .i_col_in   (col_in),
    .o_row_out  (row_out),
    .o_key_valid(key_valid),
    .o_key_code (key_code),
    .o_key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Physical keypad: which of the 20 keys are down, plus contact bounce
  logic [19:0] key_mask = 20'd0;
  bit          bouncing = 0;
  bit          en_v     = 1;

  // Reference model: plain counts of clocks and matching samples
  int m_row, m_mode, m_tick, m_run, m_col, m_code, m_pulses;
  logic [3:0] m_pat;
  bit m_valid, m_held;
  int dut_pulses = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Returns the single pressed column, or -1 for idle/ghost
  function automatic int col_idx(input logic [3:0] c);
    int zeros = 0;
    int pos = -1;
    for (int k = 0; k < 4; k++) begin
      if (!c[k]) begin
        zeros++;
        pos = k;
      end
    end
    return (zeros == 1) ? pos : -1;
  endfunction

  task automatic model_reset();
    m_row = 0; m_mode = 0; m_tick = 0; m_run = 0; m_col = 0;
    m_code = 0; m_pat = 4'hF; m_valid = 0; m_held = 0;
  endtask

  task automatic model_step(input logic [3:0] c, input bit en);
    int ci;
    ci = col_idx(c);
    m_valid = 0;
    if (!en) begin
      m_mode = 0; m_tick = 0; m_run = 0; m_held = 0;
    end else begin
      case (m_mode)
        0: begin
          m_tick++;
          if (m_tick == SCAN_DIV) begin
            m_tick = 0;
            if (ci >= 0) begin
              m_mode = 1; m_pat = c; m_col = ci; m_run = 0;
            end else begin
              m_row = (m_row + 1) % 5;
            end
          end
        end
        1: begin
          if (c != m_pat) begin
            m_mode = 0; m_tick = 0; m_run = 0;
          end else begin
            m_run++;
            if (m_run == DB_CYCLES) m_mode = 2;
          end
        end
        2: begin
          m_valid = 1; m_code = m_row * 4 + m_col; m_held = 1;
          m_mode = 3; m_run = 0;
        end
        default: begin
          if (c == 4'hF) begin
            m_run++;
            if (m_run == DB_CYCLES) begin
              m_held = 0; m_row = (m_row + 1) % 5; m_mode = 0; m_tick = 0; m_run = 0;
            end
          end else begin
            m_run = 0;
          end
        end
      endcase
    end
    if (m_valid) m_pulses++;
  endtask

  task automatic compare_all(input string when);
    check({when, "_row"},   int'(row_out),   1 << m_row);
    check({when, "_valid"}, int'(key_valid), int'(m_valid));
    check({when, "_code"},  int'(key_code),  m_code);
    check({when, "_held"},  int'(key_held),  int'(m_held));
  endtask

  // One clock: drive at negedge, step model at posedge, compare just after
  task automatic tick();
    logic [3:0] c;
    @(negedge clk);
    rst_n = 1'b1;
    c = 4'hF;
    for (int k = 0; k < 4; k++) begin
      if (key_mask[m_row * 4 + k]) c[k] = 1'b0;
    end
    if (bouncing && ($urandom % 2 == 0)) c = 4'hF;
    col_in  = c;
    scan_en = en_v;
    @(posedge clk);
    model_step(c, en_v);
    #1;
    if (key_valid) dut_pulses++;
    compare_all("cyc");
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset between edges, checked before any clock edge
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all("async_rst");
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int found, code_at, held_at, kind, k1, k2;
    rst_n = 1'b0; scan_en = 1'b1; col_in = 4'hF;
    model_reset();
    m_pulses = 0;
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");

    // Idle scanning: rotation and wrap, no strobe
    run(45);

    // Press row 1 col 1 from a clean restart: sample edge 8, strobe edge 17
    do_reset();
    key_mask = 20'd1 << 5;
    found = -1; code_at = -1; held_at = -1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (key_valid && found < 0) begin
        found = n; code_at = int'(key_code); held_at = int'(key_held);
      end
    end
    check("first_pulse_cycle", found, 17);
    check("first_code", code_at, 5);
    check("first_held", held_at, 1);
    key_mask = 20'd0;
    run(30);

    // Ghost on row 0 (two columns low)
    key_mask = 20'b11;
    run(60);
    key_mask = 20'd0;
    run(10);

    // Randomized episodes
    for (int ep = 0; ep < 60; ep++) begin
      kind = $urandom_range(0, 5);
      k1 = $urandom_range(0, 19);
      k2 = $urandom_range(0, 19);
      case (kind)
        0, 1: begin
          key_mask = 20'd1 << k1;
          bouncing = 1; run($urandom_range(0, 6));
          bouncing = 0; run($urandom_range(0, 120));
          bouncing = 1; run($urandom_range(0, 5));
          bouncing = 0; key_mask = 20'd0;
        end
        2: begin
          key_mask = (20'd1 << k1) | (20'd1 << ((k1 / 4) * 4 + (k1 + 1) % 4));
          run($urandom_range(10, 50));
          key_mask = 20'd0;
        end
        3: begin
          key_mask = 20'd1 << k1;
          run($urandom_range(20, 50));
          key_mask = key_mask | (20'd1 << k2);
          run($urandom_range(5, 30));
          key_mask = 20'd1 << k2;
          run($urandom_range(5, 40));
          key_mask = 20'd0;
        end
        4: begin
          key_mask = 20'd1 << k1;
          run($urandom_range(0, 50));
          en_v = 0; run($urandom_range(1, 10));
          en_v = 1; run($urandom_range(0, 50));
          key_mask = 20'd0;
        end
        default: begin
          key_mask = 20'd1 << k1;
          run($urandom_range(0, 40));
          do_reset();
          run($urandom_range(0, 30));
          key_mask = 20'd0;
        end
      endcase
      run($urandom_range(0, 40));
    end

    check("pulse_total", dut_pulses, m_pulses);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
